// File: rtl/wb_cdb_arbiter_pkg.sv
// Shared writeback constants: machine widths, CDB source count and the
// source index assignments used by the writeback arbiter and its users.
package wb_cdb_arbiter_pkg;

  localparam int unsigned ROB_DEPTH  = 32;
  localparam int unsigned WORD_WIDTH = 32;
  localparam int unsigned NUM_WB_SRC = 5;
  localparam int unsigned ROB_TAG_W  = $clog2(ROB_DEPTH);

  // Writeback source index of each execution unit on the CDB.
  typedef enum logic [2:0] {
    WB_SRC_ALU  = 3'd0,
    WB_SRC_MUL  = 3'd1,
    WB_SRC_DIV  = 3'd2,
    WB_SRC_LOAD = 3'd3,
    WB_SRC_BR   = 3'd4
  } wb_src_e;

endpackage

// File: rtl/wb_cdb_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   i_req     - request vector, one bit per source
//   i_ptr     - highest-priority index for this cycle (0..N-1)
//   o_grant_c - one-hot grant (all zero when no request)
//   o_idx_c   - encoded index of the granted source
//   o_any_c   - at least one request is set
module wb_cdb_arbiter_rr_pick #(
  parameter int unsigned N     = 5,
  parameter int unsigned IDX_W = 3
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant_c,
  output logic [IDX_W-1:0] o_idx_c,
  output logic             o_any_c
);

  localparam int unsigned SUM_W = IDX_W + 1;

  logic [2*N-1:0]   w_dbl;
  logic [N-1:0]     w_rot;
  logic [IDX_W-1:0] w_off;
  logic [SUM_W-1:0] w_sum;

  // Rotating the doubled vector right by ptr puts slot ptr at bit 0, so the
  // wrap from N-1 back to 0 becomes a plain lowest-bit search.
  assign w_dbl = {i_req, i_req};
  assign w_rot = N'(w_dbl >> i_ptr);

  // Lowest set bit of the rotated vector; descending loop leaves the lowest.
  always_comb begin : prio_enc
    o_any_c = 1'b0;
    w_off   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        o_any_c = 1'b1;
        w_off   = IDX_W'(k);
      end
    end
  end

  // Undo the rotation: index = (ptr + offset) mod N.
  assign w_sum     = {1'b0, i_ptr} + {1'b0, w_off};
  assign o_idx_c   = (w_sum >= SUM_W'(N)) ? IDX_W'(w_sum - SUM_W'(N)) : IDX_W'(w_sum);
  assign o_grant_c = o_any_c ? (N'(1) << o_idx_c) : '0;

endmodule

// File: rtl/wb_cdb_arbiter.sv
// Writeback arbiter: each source hands results into a private one-entry
// slot; a round-robin scheduler drains one slot per cycle onto a registered
// common data bus.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   req_valid  - per-source result valid
//   req_tag    - per-source ROB tag, source i at [i*TAG_W +: TAG_W]
//   req_data   - per-source result, source i at [i*DATA_W +: DATA_W]
//   req_ready  - per-source slot can accept (combinational)
//   flush      - drop all slots and the CDB beat, block new requests
//   cdb_valid  - CDB carries a result (registered)
//   cdb_tag    - ROB tag of the result (registered)
//   cdb_data   - result value (registered)
//   cdb_src    - index of the winning source (registered)
module wb_cdb_arbiter
  import wb_cdb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_SRC = NUM_WB_SRC,
  parameter int unsigned TAG_W   = ROB_TAG_W,
  parameter int unsigned DATA_W  = WORD_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_SRC-1:0]          req_valid,
  input  logic [NUM_SRC*TAG_W-1:0]    req_tag,
  input  logic [NUM_SRC*DATA_W-1:0]   req_data,
  output logic [NUM_SRC-1:0]          req_ready,
  input  logic                        flush,
  output logic                        cdb_valid,
  output logic [TAG_W-1:0]            cdb_tag,
  output logic [DATA_W-1:0]           cdb_data,
  output logic [$clog2(NUM_SRC)-1:0]  cdb_src
);

  localparam int unsigned SRC_W = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0] r_full;
  logic [TAG_W-1:0]   r_tag  [NUM_SRC];
  logic [DATA_W-1:0]  r_data [NUM_SRC];
  logic [SRC_W-1:0]   r_ptr;

  logic               r_cdb_valid;
  logic [TAG_W-1:0]   r_cdb_tag;
  logic [DATA_W-1:0]  r_cdb_data;
  logic [SRC_W-1:0]   r_cdb_src;

  logic [NUM_SRC-1:0] w_pick_grant;
  logic [NUM_SRC-1:0] w_grant;
  logic [NUM_SRC-1:0] w_load;
  logic [SRC_W-1:0]   w_gidx;
  logic               w_pick_any;
  logic               w_gvalid;
  logic [SRC_W-1:0]   w_ptr_nxt;
  logic [TAG_W-1:0]   w_sel_tag;
  logic [DATA_W-1:0]  w_sel_data;

  // Round-robin choice among full slots.
  wb_cdb_arbiter_rr_pick #(
    .N     (NUM_SRC),
    .IDX_W (SRC_W)
  ) u_rr_pick (
    .i_req     (r_full),
    .i_ptr     (r_ptr),
    .o_grant_c (w_pick_grant),
    .o_idx_c   (w_gidx),
    .o_any_c   (w_pick_any)
  );

  // Flush suppresses the grant so nothing drains and rr_ptr holds.
  assign w_gvalid = w_pick_any & ~flush;
  assign w_grant  = flush ? '0 : w_pick_grant;

  // A slot being drained this cycle can be refilled at the same edge.
  assign req_ready = {NUM_SRC{~flush}} & (~r_full | w_grant);
  assign w_load    = req_valid & req_ready;

  assign w_ptr_nxt = (w_gidx == SRC_W'(NUM_SRC - 1)) ? '0 : w_gidx + SRC_W'(1);

  // Payload of the granted slot (grant is one-hot, so OR-merge is exact).
  always_comb begin : sel_mux
    w_sel_tag  = '0;
    w_sel_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_grant[i]) begin
        w_sel_tag  = w_sel_tag  | r_tag[i];
        w_sel_data = w_sel_data | r_data[i];
      end
    end
  end

  // Holding slots: load on handshake, otherwise clear when drained.
  always_ff @(posedge clk or negedge rst_n) begin : slot_regs
    if (!rst_n) begin
      r_full <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        r_tag[i]  <= '0;
        r_data[i] <= '0;
      end
    end else if (flush) begin
      r_full <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (w_load[i]) begin
          r_full[i] <= 1'b1;
          r_tag[i]  <= req_tag[i*TAG_W +: TAG_W];
          r_data[i] <= req_data[i*DATA_W +: DATA_W];
        end else if (w_grant[i]) begin
          r_full[i] <= 1'b0;
        end
      end
    end
  end

  // CDB register and round-robin pointer; data fields hold on idle edges.
  always_ff @(posedge clk or negedge rst_n) begin : cdb_regs
    if (!rst_n) begin
      r_cdb_valid <= 1'b0;
      r_cdb_tag   <= '0;
      r_cdb_data  <= '0;
      r_cdb_src   <= '0;
      r_ptr       <= '0;
    end else if (w_gvalid) begin
      r_cdb_valid <= 1'b1;
      r_cdb_tag   <= w_sel_tag;
      r_cdb_data  <= w_sel_data;
      r_cdb_src   <= w_gidx;
      r_ptr       <= w_ptr_nxt;
    end else begin
      r_cdb_valid <= 1'b0;
    end
  end

  assign cdb_valid = r_cdb_valid;
  assign cdb_tag   = r_cdb_tag;
  assign cdb_data  = r_cdb_data;
  assign cdb_src   = r_cdb_src;

endmodule

// File: tb/tb_wb_cdb_arbiter.sv
// Scoreboard bench for wb_cdb_arbiter: a slot-level model predicts grants
// and pushes expected CDB beats; a negedge monitor pops and compares.
module tb_wb_cdb_arbiter;
  import wb_cdb_arbiter_pkg::*;

  localparam int N  = 5;
  localparam int TW = 5;
  localparam int DW = 32;
  localparam int SW = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*TW-1:0] req_tag;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            flush;
  logic            cdb_valid;
  logic [TW-1:0]   cdb_tag;
  logic [DW-1:0]   cdb_data;
  logic [SW-1:0]   cdb_src;

  wb_cdb_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_tag   (req_tag),
    .req_data  (req_data),
    .req_ready (req_ready),
    .flush     (flush),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .cdb_src   (cdb_src)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
    logic [SW-1:0] src;
  } beat_t;

  beat_t exp_q[$];
  beat_t last_beat;
  int checks   = 0;
  int failures = 0;

  // Behavioural model: slot contents and the next-priority source.
  bit            m_full [N];
  logic [TW-1:0] m_tag  [N];
  logic [DW-1:0] m_data [N];
  int            m_ptr;
  logic [TW-1:0] in_tag [N];
  logic [DW-1:0] in_data[N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // First full slot found scanning upward from m_ptr, wrapping modulo N.
  function automatic int pick();
    for (int k = 0; k < N; k++) begin
      if (m_full[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_full[i] = 1'b0;
      m_tag[i]  = '0;
      m_data[i] = '0;
    end
    m_ptr = 0;
    exp_q.delete();
    last_beat = '0;
  endtask

  task automatic set_src(input int i, input logic [TW-1:0] t, input logic [DW-1:0] d);
    in_tag[i]  = t;
    in_data[i] = d;
  endtask

  // One clock cycle: called at posedge+1, returns at the next posedge+1.
  task automatic cycle(input logic [N-1:0] v, input logic fl);
    int           g;
    logic [N-1:0] rdy;
    beat_t        b;
    req_valid = v;
    flush     = fl;
    for (int i = 0; i < N; i++) begin
      req_tag[i*TW +: TW]  = in_tag[i];
      req_data[i*DW +: DW] = in_data[i];
    end
    g = fl ? -1 : pick();
    for (int i = 0; i < N; i++) rdy[i] = !fl && (!m_full[i] || g == i);
    #1;
    chk("req_ready", 64'(req_ready), 64'(rdy));
    @(posedge clk);
    #1;
    if (g >= 0) begin
      b.tag  = m_tag[g];
      b.data = m_data[g];
      b.src  = SW'(g);
      exp_q.push_back(b);
      m_ptr = (g == N - 1) ? 0 : g + 1;
    end
    for (int i = 0; i < N; i++) begin
      if (fl) m_full[i] = 1'b0;
      else if (v[i] && rdy[i]) begin
        m_full[i] = 1'b1;
        m_tag[i]  = in_tag[i];
        m_data[i] = in_data[i];
      end else if (g == i) m_full[i] = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle('0, 1'b0);
  endtask

  // Monitor: one expected beat per cycle in which the model granted.
  initial begin : monitor
    beat_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("cdb_valid", 64'(cdb_valid), 64'd1);
          chk("cdb_tag", 64'(cdb_tag), 64'(e.tag));
          chk("cdb_data", 64'(cdb_data), 64'(e.data));
          chk("cdb_src", 64'(cdb_src), 64'(e.src));
          last_beat = e;
        end else begin
          chk("cdb_idle", 64'(cdb_valid), 64'd0);
          chk("cdb_hold_data", 64'(cdb_data), 64'(last_beat.data));
          chk("cdb_hold_src", 64'(cdb_src), 64'(last_beat.src));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin : stim
    logic [N-1:0] v;
    rst_n     = 1'b0;
    req_valid = '0;
    req_tag   = '0;
    req_data  = '0;
    flush     = 1'b0;
    for (int i = 0; i < N; i++) set_src(i, '0, '0);
    model_reset();
    #1;
    chk("rst_cdb_valid", 64'(cdb_valid), 64'd0);
    chk("rst_cdb_tag", 64'(cdb_tag), 64'd0);
    chk("rst_cdb_data", 64'(cdb_data), 64'd0);
    chk("rst_cdb_src", 64'(cdb_src), 64'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single ALU result.
    set_src(int'(WB_SRC_ALU), 5'd5, 32'h1234);
    cycle(5'b00001, 1'b0);
    idle(3);

    // All five sources at once, tags 1..5.
    for (int i = 0; i < N; i++) set_src(i, TW'(i + 1), 32'hA000 + DW'(i));
    cycle(5'b11111, 1'b0);
    idle(7);

    // Wrap: LOAD win moves the pointer to BR, then BR and ALU compete
    // with ALU re-requesting every cycle and MUL arriving later.
    set_src(int'(WB_SRC_LOAD), 5'd9, 32'h0000_0D0D);
    cycle(5'b01000, 1'b0);
    set_src(int'(WB_SRC_BR), 5'd10, 32'h0000_B0B0);
    set_src(int'(WB_SRC_ALU), 5'd11, 32'h0000_A1A1);
    cycle(5'b10001, 1'b0);
    for (int k = 0; k < 8; k++) begin
      set_src(int'(WB_SRC_ALU), TW'(12 + k), 32'hAA00 + DW'(k));
      set_src(int'(WB_SRC_MUL), 5'd30, 32'h0000_3030);
      cycle((k == 2) ? 5'b00011 : 5'b00001, 1'b0);
    end
    idle(6);

    // MUL streaming alone: same-cycle refill, no bubbles.
    for (int k = 0; k < 5; k++) begin
      set_src(int'(WB_SRC_MUL), TW'(20 + k), 32'h5500 + DW'(k));
      cycle(5'b00010, 1'b0);
    end
    idle(3);

    // Flush with three full slots and a live CDB beat.
    for (int i = 0; i < N; i++) set_src(i, TW'(i + 16), 32'hF000 + DW'(i));
    cycle(5'b00111, 1'b0);
    cycle(5'b01000, 1'b0);
    cycle(5'b10001, 1'b1);
    idle(4);
    // Pointer held across flush: ALU vs MUL shows who has priority.
    set_src(int'(WB_SRC_ALU), 5'd1, 32'h0101);
    set_src(int'(WB_SRC_MUL), 5'd2, 32'h0202);
    cycle(5'b00011, 1'b0);
    idle(4);

    // Randomised traffic with occasional flushes.
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++) set_src(i, TW'($urandom), DW'($urandom));
      v = N'($urandom) & N'($urandom | $urandom);
      cycle(v, ($urandom_range(0, 31) == 0));
    end
    idle(6);

    // Asynchronous reset in the middle of a MUL stream.
    for (int k = 0; k < 3; k++) begin
      set_src(int'(WB_SRC_MUL), TW'(k + 7), 32'hC0DE_0000 + DW'(k));
      cycle(5'b00010, 1'b0);
    end
    req_valid = '0;
    #2;
    chk("pre_rst_valid", 64'(cdb_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst_valid", 64'(cdb_valid), 64'd0);
    chk("async_rst_data", 64'(cdb_data), 64'd0);
    chk("async_rst_src", 64'(cdb_src), 64'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    set_src(int'(WB_SRC_ALU), 5'd3, 32'h3333);
    set_src(int'(WB_SRC_DIV), 5'd4, 32'h4444);
    cycle(5'b00101, 1'b0);
    idle(5);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
